// File: rtl/route_exchange_ram_if.sv
// Bus bundle for route_exchange_ram: write sources, streaming read port,
// random-access lookup port and the read-FSM state for observation.
//
// Handshake semantics: there is no backpressure anywhere. A source word is
// taken on any rising edge where src_valid[wr_src] is high; rd_valid marks a
// valid rd_data beat that the consumer must take in that same cycle; rd_start
// is a single-cycle request that only takes effect while busy is low.
interface route_exchange_ram_if #(
    parameter int LANES = 8,
    parameter int IDX_W = 7,
    parameter int WORDS = 16,
    parameter int BASES = 4,
    parameter int NSRC  = 3
) ();
    localparam int WORD_W = LANES * IDX_W;
    localparam int BASE_W = (BASES > 1) ? $clog2(BASES) : 1;
    localparam int SRC_W  = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int LK_W   = $clog2(LANES * WORDS);

    logic [NSRC-1:0]        src_valid;
    logic [NSRC*WORD_W-1:0] src_data;
    logic [SRC_W-1:0]       wr_src;
    logic [BASE_W-1:0]      wr_base;
    logic                   wr_done;

    logic                   rd_start;
    logic [BASE_W-1:0]      rd_base;
    logic                   rd_valid;
    logic [WORD_W-1:0]      rd_data;
    logic                   rd_last;
    logic                   busy;

    logic [BASE_W-1:0]      lk_base;
    logic [LK_W-1:0]        lk_addr;
    logic [IDX_W-1:0]       lk_data;

    logic [1:0]             rd_state;

    modport master (
        output src_valid, src_data, wr_src, wr_base, rd_start, rd_base, lk_base, lk_addr,
        input  wr_done, rd_valid, rd_data, rd_last, busy, lk_data, rd_state
    );

    modport slave (
        input  src_valid, src_data, wr_src, wr_base, rd_start, rd_base, lk_base, lk_addr,
        output wr_done, rd_valid, rd_data, rd_last, busy, lk_data, rd_state
    );
endinterface

// File: rtl/route_exchange_ram.sv
// Route exchange RAM: holds BASES routes of WORDS packed words (LANES city
// indices each). One selectable source writes whole-route bursts, a small FSM
// streams a route out word by word, and a lookup port returns single city
// indices every cycle. All three run concurrently; reads are read-first.
module route_exchange_ram #(
    parameter int LANES = 8,
    parameter int IDX_W = 7,
    parameter int WORDS = 16,
    parameter int BASES = 4,
    parameter int NSRC  = 3
) (
    input  logic           clk,
    input  logic           reset,
    route_exchange_ram_if.slave bus
);
    localparam int WORD_W  = LANES * IDX_W;
    localparam int BASE_W  = (BASES > 1) ? $clog2(BASES) : 1;
    localparam int SRC_W   = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int LK_W    = $clog2(LANES * WORDS);
    localparam int WORD_AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int ADDR_W  = BASE_W + WORD_AW;
    localparam int DEPTH   = 1 << ADDR_W;

    localparam logic [WORD_AW-1:0] LAST_WORD = WORD_AW'(WORDS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic               wr_strobe;
    logic [WORD_W-1:0]  wr_word;
    logic [WORD_AW-1:0] wcount;
    logic [BASE_W-1:0]  wr_base_q;
    logic [BASE_W-1:0]  wr_base_eff;
    logic [ADDR_W-1:0]  wr_addr;
    logic               wr_en;
    logic               wr_done_q;

    // Pick the strobe and word of the selected source; out-of-range selects never write.
    always_comb begin
        wr_strobe = 1'b0;
        wr_word   = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (bus.wr_src == SRC_W'(i)) begin
                wr_strobe = bus.src_valid[i];
                wr_word   = bus.src_data[i*WORD_W +: WORD_W];
            end
        end
    end

    // The first word of a burst takes the live wr_base; later words reuse the latched one.
    assign wr_base_eff = (wcount == '0) ? bus.wr_base : wr_base_q;
    assign wr_addr     = {wr_base_eff, wcount};
    assign wr_en       = wr_strobe && !reset;

    // Burst word counter, burst base latch and the burst-complete pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            wcount    <= '0;
            wr_base_q <= '0;
            wr_done_q <= 1'b0;
        end else begin
            wr_done_q <= wr_strobe && (wcount == LAST_WORD);
            if (wr_strobe) begin
                wr_base_q <= wr_base_eff;
                wcount    <= (wcount == LAST_WORD) ? '0 : wcount + WORD_AW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stream read FSM
    // ------------------------------------------------------------------
    logic [1:0]         rd_state;
    logic [WORD_AW-1:0] rd_addr;
    logic [BASE_W-1:0]  rd_base_q;
    logic               drain_cnt;
    logic               rd_issue;
    logic               rd_issue_last;

    // IDLE waits for a request, READ issues one address per cycle, DRAIN
    // covers the two pipeline stages so busy stays high until the last beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state  <= ST_IDLE;
            rd_addr   <= '0;
            rd_base_q <= '0;
            drain_cnt <= 1'b0;
        end else begin
            case (rd_state)
                ST_IDLE: begin
                    if (bus.rd_start) begin
                        rd_state  <= ST_READ;
                        rd_base_q <= bus.rd_base;
                        rd_addr   <= '0;
                    end
                end
                ST_READ: begin
                    if (rd_addr == LAST_WORD) begin
                        rd_state  <= ST_DRAIN;
                        drain_cnt <= 1'b0;
                    end else begin
                        rd_addr <= rd_addr + WORD_AW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt) begin
                        rd_state <= ST_IDLE;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: rd_state <= ST_IDLE;
            endcase
        end
    end

    assign rd_issue      = (rd_state == ST_READ);
    assign rd_issue_last = rd_issue && (rd_addr == LAST_WORD);

    // ------------------------------------------------------------------
    // Storage: one write port, two registered read ports (stream, lookup)
    // ------------------------------------------------------------------
    logic [WORD_W-1:0]  mem [DEPTH];
    logic [WORD_W-1:0]  rd_q;
    logic [WORD_W-1:0]  lk_word_q;
    logic [LANE_W-1:0]  lk_lane_q;
    logic [WORD_AW-1:0] lk_word_idx;
    logic [LANE_W-1:0]  lk_lane;
    logic [ADDR_W-1:0]  lk_ram_addr;

    assign lk_word_idx = WORD_AW'(bus.lk_addr / LK_W'(LANES));
    assign lk_lane     = LANE_W'(bus.lk_addr % LK_W'(LANES));
    assign lk_ram_addr = {bus.lk_base, lk_word_idx};

    // RAM array and its read registers; contents survive reset and reads see pre-write data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_word;
        end
        rd_q      <= mem[{rd_base_q, rd_addr}];
        lk_word_q <= mem[lk_ram_addr];
        lk_lane_q <= lk_lane;
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    logic              rd_v1;
    logic              rd_l1;
    logic              rd_valid_q;
    logic              rd_last_q;
    logic [WORD_W-1:0] rd_data_q;
    logic [IDX_W-1:0]  lk_lane_val;
    logic [IDX_W-1:0]  lk_data_q;

    // Select the requested city index out of the looked-up word.
    always_comb begin
        lk_lane_val = '0;
        for (int j = 0; j < LANES; j++) begin
            if (lk_lane_q == LANE_W'(j)) begin
                lk_lane_val = lk_word_q[j*IDX_W +: IDX_W];
            end
        end
    end

    // Valid/last ride alongside the RAM read register, then the output register; data holds between beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_v1      <= 1'b0;
            rd_l1      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
            lk_data_q  <= '0;
        end else begin
            rd_v1      <= rd_issue;
            rd_l1      <= rd_issue_last;
            rd_valid_q <= rd_v1;
            rd_last_q  <= rd_l1;
            if (rd_v1) begin
                rd_data_q <= rd_q;
            end
            lk_data_q  <= lk_lane_val;
        end
    end

    assign bus.wr_done  = wr_done_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_last  = rd_last_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.busy     = (rd_state != ST_IDLE);
    assign bus.lk_data  = lk_data_q;
    assign bus.rd_state = rd_state;
endmodule

// File: tb/tb_route_exchange_ram.sv
// Bench for route_exchange_ram: random and directed traffic on all three
// ports, a route-level reference model (arrays of routes, cycle arithmetic
// for stream/lookup timing) and a negedge monitor draining expected queues.
module tb_route_exchange_ram;
    localparam int LANES  = 8;
    localparam int IDX_W  = 7;
    localparam int WORDS  = 16;
    localparam int BASES  = 4;
    localparam int NSRC   = 3;
    localparam int WORD_W = LANES * IDX_W;
    localparam int RLEN   = LANES * WORDS;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    route_exchange_ram_if #(.LANES(LANES), .IDX_W(IDX_W), .WORDS(WORDS),
                            .BASES(BASES), .NSRC(NSRC)) bus ();

    route_exchange_ram #(.LANES(LANES), .IDX_W(IDX_W), .WORDS(WORDS),
                         .BASES(BASES), .NSRC(NSRC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- reference model ----------------
    typedef struct { int due; logic [WORD_W-1:0] data; logic last; } beat_t;
    typedef struct { int due; bit chk; logic [IDX_W-1:0] val; } lk_t;

    logic [WORD_W-1:0] route_m [BASES][WORDS];
    bit                known_m [BASES][WORDS];
    beat_t             beat_q[$];
    lk_t               lk_q[$];
    int                done_q[$];
    logic [WORD_W-1:0] hold_m = '0;
    int                wc_m = 0;
    int                burst_base_m = 0;
    int                s_start = -1000;
    int                s_base = 0;
    int                cyc = 0;
    bit                mon_on = 1'b0;
    bit                lk_hold = 1'b0;
    int                n_cmp = 0;
    int                n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic bit stream_busy(input int t);
        return (t >= s_start + 1) && (t <= s_start + WORDS + 2);
    endfunction

    // Advance the model across the clock edge that ends cycle cyc.
    task automatic model_step();
        int t, k, w, lane, ws, b;
        beat_t bt;
        lk_t lt;
        t = cyc;
        if (reset) begin
            beat_q.delete();
            done_q.delete();
            hold_m  = '0;
            s_start = -1000;
            wc_m    = 0;
            while (lk_q.size() > 0 && lk_q[0].due == t + 1) void'(lk_q.pop_front());
            lt.due = t + 1; lt.chk = 1'b1; lt.val = '0;
            lk_q.push_front(lt);
            mon_on = 1'b1;
            return;
        end
        // Reads see the route contents before this edge's write.
        if (t >= s_start + 1 && t <= s_start + WORDS) begin
            k = t - s_start - 1;
            bt.due = t + 2; bt.data = route_m[s_base][k]; bt.last = (k == WORDS - 1);
            beat_q.push_back(bt);
        end
        b = int'(bus.lk_base);
        w = int'(bus.lk_addr) / LANES;
        lane = int'(bus.lk_addr) % LANES;
        lt.due = t + 2; lt.chk = known_m[b][w]; lt.val = route_m[b][w][lane*IDX_W +: IDX_W];
        lk_q.push_back(lt);
        // Write burst bookkeeping.
        ws = int'(bus.wr_src);
        if (ws < NSRC) begin
            if (bus.src_valid[ws]) begin
                if (wc_m == 0) burst_base_m = int'(bus.wr_base);
                route_m[burst_base_m][wc_m] = bus.src_data[ws*WORD_W +: WORD_W];
                known_m[burst_base_m][wc_m] = 1'b1;
                if (wc_m == WORDS - 1) done_q.push_back(t + 1);
                wc_m = (wc_m + 1) % WORDS;
            end
        end
        if (bus.rd_start && !stream_busy(t)) begin
            s_start = t;
            s_base  = int'(bus.rd_base);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic              m_v, m_l, m_done, m_busy;
    logic [WORD_W-1:0] m_d;
    beat_t             m_bt;
    lk_t               m_lt;

    always @(negedge clk) begin
        if (mon_on) begin
            m_v = 1'b0; m_l = 1'b0; m_d = hold_m;
            while (beat_q.size() > 0 && beat_q[0].due < cyc) void'(beat_q.pop_front());
            if (beat_q.size() > 0 && beat_q[0].due == cyc) begin
                m_bt = beat_q.pop_front();
                m_v = 1'b1; m_l = m_bt.last; m_d = m_bt.data;
                hold_m = m_bt.data;
            end
            check("rd_stream", 64'({bus.rd_valid, bus.rd_last, bus.rd_data}), 64'({m_v, m_l, m_d}));

            m_done = 1'b0;
            if (done_q.size() > 0 && done_q[0] == cyc) begin
                void'(done_q.pop_front());
                m_done = 1'b1;
            end
            check("wr_done", 64'(bus.wr_done), 64'(m_done));

            m_busy = stream_busy(cyc);
            check("busy", 64'(bus.busy), 64'(m_busy));

            while (lk_q.size() > 0 && lk_q[0].due < cyc) void'(lk_q.pop_front());
            if (lk_q.size() > 0 && lk_q[0].due == cyc) begin
                m_lt = lk_q.pop_front();
                if (m_lt.chk) check("lk_data", 64'(bus.lk_data), 64'(m_lt.val));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        if (!lk_hold) begin
            bus.lk_base = $urandom_range(0, BASES - 1);
            bus.lk_addr = $urandom_range(0, RLEN - 1);
        end
        @(negedge clk);
        #1;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        bus.rd_start  = 1'b0;
        bus.src_valid = '0;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NSRC; i++)
            bus.src_data[i*WORD_W +: WORD_W] = WORD_W'({$urandom(), $urandom()});
    endtask

    task automatic rand_write_cycle();
        bus.wr_src    = $urandom_range(0, 3);
        bus.src_valid = $urandom_range(0, 7);
        bus.wr_base   = $urandom_range(0, BASES - 1);
        rand_data();
    endtask

    // One full route burst; wr_base moves to base2 from word switch_at on.
    task automatic write_burst(input int src, input int base, input int base2,
                               input int switch_at, input bit count_data);
        for (int w = 0; w < WORDS; w++) begin
            bus.wr_src  = src;
            bus.wr_base = (w >= switch_at) ? base2 : base;
            if ($urandom_range(0, 3) == 0) begin
                rand_data();
                bus.src_valid = $urandom_range(0, 7);
                bus.src_valid[src] = 1'b0;
                tick();
                bus.wr_src  = src;
                bus.wr_base = (w >= switch_at) ? base2 : base;
            end
            rand_data();
            if (count_data) bus.src_data[src*WORD_W +: WORD_W] = WORD_W'(32'h10 + w);
            bus.src_valid = $urandom_range(0, 7);
            bus.src_valid[src] = 1'b1;
            tick();
        end
    endtask

    task automatic stream(input int base, input int idle);
        bus.rd_start = 1'b1;
        bus.rd_base  = base;
        tick();
        repeat (idle) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset         = 1'b1;
        bus.src_valid = '0;
        bus.src_data  = '0;
        bus.wr_src    = '0;
        bus.wr_base   = '0;
        bus.rd_start  = 1'b0;
        bus.rd_base   = '0;
        bus.lk_base   = '0;
        bus.lk_addr   = '0;
        @(posedge clk);
        #1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();

        // Fill every route; base 2 gets the counting pattern 0x10..0x1F from source 1.
        write_burst(0, 0, 0, WORDS, 1'b0);
        write_burst(2, 1, 1, WORDS, 1'b0);
        write_burst(1, 2, 2, WORDS, 1'b1);
        write_burst(0, 3, 3, WORDS, 1'b0);
        repeat (2) tick();

        // Stream the counting route.
        stream(2, 24);

        // Sweep every city index of route 2 through the lookup port.
        lk_hold = 1'b1;
        bus.lk_base = 2;
        for (int a = 0; a < RLEN; a++) begin
            bus.lk_addr = a;
            tick();
        end
        lk_hold = 1'b0;
        repeat (3) tick();

        // Base change mid-burst is ignored; then a burst really aimed at base 3.
        write_burst(1, 2, 3, 5, 1'b0);
        stream(2, 20);
        stream(3, 20);
        write_burst(2, 3, 3, WORDS, 1'b0);
        stream(3, 20);

        // Out-of-range source select and a strobe on a non-selected source.
        for (int i = 0; i < 5; i++) begin
            bus.wr_src = 2'd3; bus.src_valid = 3'b111; bus.wr_base = 0; rand_data();
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            bus.wr_src = 2'd1; bus.src_valid = 3'b001; bus.wr_base = 0; rand_data();
            tick();
        end
        write_burst(1, 1, 1, WORDS, 1'b0);
        stream(1, 20);

        // Requests while busy: c+5 and c+18 ignored, c+19 accepted; writes run alongside.
        for (int i = 0; i < 42; i++) begin
            rand_write_cycle();
            bus.rd_start = (i == 0) || (i == 5) || (i == 18) || (i == 19);
            bus.rd_base  = (i == 19) ? 1 : $urandom_range(0, BASES - 1);
            tick();
        end

        // Reset eight cycles into a stream while a burst is half written.
        write_burst(0, 2, 2, WORDS, 1'b0);
        for (int i = 0; i < 8; i++) begin
            bus.rd_start = (i == 0);
            bus.rd_base  = 2;
            bus.wr_src = 0; bus.wr_base = 0; rand_data();
            bus.src_valid = 3'b001;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        write_burst(2, 0, 0, WORDS, 1'b0);
        stream(0, 20);

        // Random concurrent traffic with occasional resets.
        for (int i = 0; i < 900; i++) begin
            rand_write_cycle();
            bus.rd_start = ($urandom_range(0, 7) == 0);
            bus.rd_base  = $urandom_range(0, BASES - 1);
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;
        repeat (25) tick();

        check("beats_left", 64'(beat_q.size()), 64'd0);
        check("done_left", 64'(done_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/route_exchange_ram.md
ROUTE_EXCHANGE_RAM -- requirements
Module: route_exchange_ram

Interface
REQ-001 SHALL have parameter LANES, default 8, city indices per RAM word.
REQ-002 SHALL have parameter IDX_W, default 7, city index width; WORD_W = LANES*IDX_W.
REQ-003 SHALL have parameter WORDS, default 16, words per route (route length LANES*WORDS).
REQ-004 SHALL have parameter BASES, default 4, route slots held; BASE_W = $clog2(BASES).
REQ-005 SHALL have parameter NSRC, default 3, write source channels; SRC_W = $clog2(NSRC) (min 1).
REQ-006 SHALL have ports: clk in 1 clock; reset in 1 synchronous, active-high.
REQ-007 SHALL have ports: src_valid in NSRC per-source word strobe; src_data in NSRC*WORD_W, source i at bits [i*WORD_W +: WORD_W].
REQ-008 SHALL have ports: wr_src in SRC_W selected source; wr_base in BASE_W target slot; wr_done out 1 burst-complete pulse.
REQ-009 SHALL have ports: rd_start in 1; rd_base in BASE_W; rd_valid out 1; rd_data out WORD_W; rd_last out 1; busy out 1.
REQ-010 SHALL have ports: lk_base in BASE_W; lk_addr in $clog2(LANES*WORDS); lk_data out IDX_W.

Function
REQ-011 SHALL hold BASES*WORDS words of WORD_W bits in one RAM, address {base, word}.
REQ-012 Write strobe SHALL be src_valid[wr_src]; wr_src >= NSRC SHALL give no write.
REQ-013 Write word counter wcount SHALL start at 0 and advance per strobe, wrapping WORDS-1 -> 0.
REQ-014 wr_base SHALL be latched when the strobe occurs with wcount==0 and used for that whole burst; wr_base changes mid-burst SHALL be ignored.
REQ-015 Strobed word SHALL be written at {burst base, wcount} on the same edge.
REQ-016 wr_done SHALL pulse high exactly one cycle, the cycle after the word with wcount==WORDS-1 is written.
REQ-017 Read FSM states SHALL be IDLE, READ, DRAIN; busy SHALL be high in READ and DRAIN.
REQ-018 IDLE -> READ on rd_start; rd_base latched; read address counter set to 0.
REQ-019 READ SHALL issue one address per cycle, 0..WORDS-1, then go to DRAIN.
REQ-020 DRAIN SHALL last 2 cycles, then return to IDLE.
REQ-021 rd_start while busy SHALL be ignored.
REQ-022 rd_start high in cycle c SHALL present word k with rd_valid=1 in cycle c+3+k, k=0..WORDS-1.
REQ-023 Output timing: RAM read register, then output register; rd_valid high WORDS consecutive cycles.
REQ-024 rd_last SHALL be high with word WORDS-1 only; rd_data SHALL hold its last value while rd_valid=0.
REQ-025 Lookup port SHALL read word {lk_base, lk_addr/LANES}, lane lk_addr%LANES (lane j = bits [j*IDX_W +: IDX_W]).
REQ-026 Lookup latency SHALL be 2 cycles: lk_addr in cycle c -> lk_data in cycle c+2; it operates every cycle, independent of the FSM.
REQ-027 Read-during-write to the same address, stream or lookup, SHALL return the old contents (read-first).
REQ-028 Writes, streaming reads and lookups SHALL proceed concurrently without stalls.

Reset
REQ-029 Reset SHALL force: FSM IDLE, wcount 0, rd_valid 0, rd_last 0, rd_data 0, wr_done 0, busy 0, lk_data 0.
REQ-030 Reset SHALL abort any write burst or stream in progress; no rd_valid SHALL follow.
REQ-031 RAM contents SHALL NOT be reset.

Verification
REQ-032 Defaults: select src 1, base 2, 16 strobes of word w = 0x10+w -> wr_done one cycle after the 16th; stream base 2 -> rd_valid c+3..c+18, data 0x10..0x1F, rd_last at 0x1F.
REQ-033 Lookup base 2, lk_addr 0..127 each cycle -> lk_data(c+2) = lane lk_addr%8 of word lk_addr/8; check lanes 0 and 7.
REQ-034 Switch wr_base 2->3 at word 5 -> all 16 words land in base 2; base 3 unchanged; second burst to base 3 wraps wcount 15->0.
REQ-035 wr_src=3 with src_valid=3'b111 -> no write, wcount stays 0; src_valid[0] only with wr_src=1 -> no write.
REQ-036 rd_start again at c+5 -> ignored, exactly 16 rd_valid beats; rd_start in the cycle busy drops -> new stream accepted.
REQ-037 Reset at c+8 of a stream and mid write burst -> rd_valid 0 from the next cycle, busy 0, next burst writes from word 0.
